fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register and the F/D pipeline register.
- Selects the next PC from four sources: sequential, branch (the D-stage compare result), j/jal, and jr. Honours the hazard-unit stall.
- Delivers Instr_D/PC_D/PC8_D to the decode stage. Architectural branch delay slot: the slot instruction is never squashed.
- Instruction memory is external. This block drives PC_F and receives Instr_F combinationally in the same cycle.

---
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register
// and the F/D pipeline register. The branch delay slot is architectural:
// the instruction fetched while a redirect is decided always enters D.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   Stall       hazard-unit stall; freezes PC and the F/D register
//   Branch      D-stage compare result, branch taken
//   Jump        D-stage instruction is j/jal
//   JumpReg     D-stage instruction is jr/jalr
//   RegAddr     forwarded rs value, the jr/jalr target
//   Instr_F     instruction word returned by instruction memory for PC_F
//   PC_F        current fetch address
//   Instr_D     F/D register: instruction (nop when the fetch faulted)
//   PC_D        F/D register: address of Instr_D
//   PC8_D       F/D register: PC_D + 8, link value for jal/jalr
//   FetchErr_D  F/D register: fetch was misaligned or outside instruction memory
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] RegAddr,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        FetchErr_D
);

  // Address of the last legal instruction word.
  localparam logic [31:0] IM_LAST = IM_BASE + (32'(IM_WORDS) * 32'd4) - 32'd4;

  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] nextPc;
  logic        fetchErr;

  // Redirect targets are decoded from the instruction already sitting in D;
  // the branch offset is a sign-extended word offset relative to the slot.
  always_comb begin
    branchTarget = PC_D + 32'd4 + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
    jumpTarget   = {PC_D[31:28], Instr_D[25:0], 2'b00};
  end

  // Next-PC selection. The register-indirect jump wins over the others so a
  // misbehaving upstream cannot produce a blended target; stall is applied
  // at the register, so this path never sees it.
  always_comb begin
    nextPc = PC_F + 32'd4;
    if (JumpReg) begin
      nextPc = RegAddr;
    end else if (Jump) begin
      nextPc = jumpTarget;
    end else if (Branch) begin
      nextPc = branchTarget;
    end
  end

  // A fetch faults when the address is not word aligned or falls outside the
  // instruction memory window. A wrapped PC of 0 lands below the base.
  always_comb begin
    fetchErr = (PC_F[1:0] != 2'b00) || (PC_F < IM_BASE) || (PC_F > IM_LAST);
  end

  // PC and F/D register. A faulting fetch is replaced by a nop so the bogus
  // word never decodes; the PC keeps advancing from the faulting address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_F       <= RESET_PC;
      Instr_D    <= 32'd0;
      PC_D       <= 32'd0;
      PC8_D      <= 32'd8;
      FetchErr_D <= 1'b0;
    end else if (!Stall) begin
      PC_F       <= nextPc;
      Instr_D    <= fetchErr ? 32'd0 : Instr_F;
      PC_D       <= PC_F;
      PC8_D      <= PC_F + 32'd8;
      FetchErr_D <= fetchErr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage. A word-array instruction memory feeds
// Instr_F, a behavioural pipeline model tracks what the fetch stage must hold,
// and directed vectors walk through branches, jumps, stalls, faults and reset.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        Branch;
  logic        Jump;
  logic        JumpReg;
  logic [31:0] RegAddr;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        FetchErr_D;

  logic [31:0] im [0:1023];

  int checks   = 0;
  int failures = 0;
  bit modelReady = 0;

  logic [31:0] mPc    = 32'h0000_3000;
  logic [31:0] mInstr = 32'd0;
  logic [31:0] mPcD   = 32'd0;
  logic [31:0] mPc8   = 32'd8;
  logic        mErr   = 1'b0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .Branch     (Branch),
    .Jump       (Jump),
    .JumpReg    (JumpReg),
    .RegAddr    (RegAddr),
    .Instr_F    (Instr_F),
    .PC_F       (PC_F),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .PC8_D      (PC8_D),
    .FetchErr_D (FetchErr_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A legal address is a whole word inside the 4 KiB window above BASE.
  function automatic bit legalAddr(input logic [31:0] a);
    longint unsigned ua;
    ua = longint'(a);
    return (ua % 4 == 0) && (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4096);
  endfunction

  // Out-of-window reads return a recognisable junk word that must never reach D.
  function automatic logic [31:0] imRead(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (legalAddr(a)) return im[off[11:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb Instr_F = imRead(PC_F);

  // Behavioural model of the fetch stage: where the next fetch goes and what
  // the decode stage receives, derived from the instruction-set rules.
  always @(posedge clk or negedge reset) begin
    longint target;
    if (!reset) begin
      mPc    <= BASE;
      mInstr <= 32'd0;
      mPcD   <= 32'd0;
      mPc8   <= 32'd8;
      mErr   <= 1'b0;
    end else if (!Stall) begin
      if (JumpReg)     target = longint'(RegAddr);
      else if (Jump)   target = longint'(mPcD & 32'hF000_0000) + longint'(mInstr[25:0]) * 4;
      else if (Branch) target = longint'(mPcD) + 4 + 4 * longint'($signed(mInstr[15:0]));
      else             target = longint'(mPc) + 4;
      mPc    <= 32'(target);
      mInstr <= legalAddr(mPc) ? imRead(mPc) : 32'd0;
      mPcD   <= mPc;
      mPc8   <= 32'(longint'(mPc) + 8);
      mErr   <= !legalAddr(mPc);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge the DUT registers must match the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("model PC_F", PC_F, mPc);
      checkOutput("model Instr_D", Instr_D, mInstr);
      checkOutput("model PC_D", PC_D, mPcD);
      checkOutput("model PC8_D", PC8_D, mPc8);
      checkOutput("model FetchErr_D", {31'd0, FetchErr_D}, {31'd0, mErr});
    end
  end

  // Drive one cycle of control inputs at a falling edge, then let one rising
  // edge happen and return at the next falling edge.
  task automatic applyStimulus(input logic st, input logic br, input logic j,
                               input logic jr, input logic [31:0] ra);
    Stall   = st;
    Branch  = br;
    Jump    = j;
    JumpReg = jr;
    RegAddr = ra;
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " PC_F"}, PC_F, 32'h0000_3000);
    checkOutput({tag, " Instr_D"}, Instr_D, 32'd0);
    checkOutput({tag, " PC_D"}, PC_D, 32'd0);
    checkOutput({tag, " PC8_D"}, PC8_D, 32'd8);
    checkOutput({tag, " FetchErr_D"}, {31'd0, FetchErr_D}, 32'd0);
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    for (int i = 0; i < 1024; i++) im[i] = 32'hA000_0000 | 32'(i);
    im[0] = 32'h1111_1111;
    im[1] = 32'h1000_0003;
    im[2] = 32'h3333_3333;
    im[3] = 32'h4444_4444;
    im[4] = 32'h1000_FFFE;
    im[5] = 32'h0800_0C04;
    im[6] = 32'h7777_7777;
    im[7] = 32'h8888_8888;
    im[8] = 32'h0C00_0C10;

    reset   = 1'b0;
    Stall   = 1'b0;
    Branch  = 1'b0;
    Jump    = 1'b0;
    JumpReg = 1'b0;
    RegAddr = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    modelReady = 1'b1;
    checkResetValues("reset");

    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("seq PC_F 1", PC_F, 32'h0000_3004);
    checkOutput("seq Instr_D 1", Instr_D, 32'h1111_1111);
    checkOutput("seq PC_D 1", PC_D, 32'h0000_3000);
    checkOutput("seq PC8_D 1", PC8_D, 32'h0000_3008);

    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("seq PC_F 2", PC_F, 32'h0000_3008);
    checkOutput("beq in D", Instr_D, 32'h1000_0003);

    applyStimulus(0, 1, 0, 0, 32'd0);
    checkOutput("beq target", PC_F, 32'h0000_3014);
    checkOutput("slot Instr_D", Instr_D, 32'h3333_3333);
    checkOutput("slot PC_D", PC_D, 32'h0000_3008);

    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("j in D PC_D", PC_D, 32'h0000_3014);
    applyStimulus(0, 0, 1, 0, 32'd0);
    checkOutput("j target", PC_F, 32'h0000_3010);

    applyStimulus(0, 0, 0, 0, 32'd0);
    applyStimulus(0, 1, 0, 0, 32'd0);
    checkOutput("backward branch target", PC_F, 32'h0000_300C);

    applyStimulus(0, 0, 0, 0, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0);
    applyStimulus(1, 1, 0, 0, 32'd0);
    applyStimulus(1, 1, 0, 0, 32'd0);
    checkOutput("stall PC_F", PC_F, 32'h0000_3014);
    checkOutput("stall Instr_D", Instr_D, 32'h1000_FFFE);
    checkOutput("stall PC_D", PC_D, 32'h0000_3010);

    applyStimulus(0, 1, 0, 0, 32'd0);
    checkOutput("post-stall target", PC_F, 32'h0000_300C);
    checkOutput("post-stall PC_D", PC_D, 32'h0000_3014);
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("redirect once", PC_F, 32'h0000_3010);

    repeat (5) applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("jal PC_D", PC_D, 32'h0000_3020);
    checkOutput("jal PC8_D", PC8_D, 32'h0000_3028);
    checkOutput("jal Instr_D", Instr_D, 32'h0C00_0C10);
    applyStimulus(0, 0, 1, 0, 32'd0);
    checkOutput("jal target", PC_F, 32'h0000_3040);

    applyStimulus(0, 0, 0, 0, 32'd0);
    applyStimulus(0, 0, 1, 1, 32'h0000_3100);
    checkOutput("jr over j", PC_F, 32'h0000_3100);

    applyStimulus(0, 0, 0, 0, 32'd0);
    applyStimulus(0, 0, 0, 1, 32'h0000_3102);
    checkOutput("jr misaligned PC_F", PC_F, 32'h0000_3102);
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("misaligned Instr_D", Instr_D, 32'd0);
    checkOutput("misaligned FetchErr_D", {31'd0, FetchErr_D}, 32'd1);
    checkOutput("misaligned PC_D", PC_D, 32'h0000_3102);
    checkOutput("misaligned next PC_F", PC_F, 32'h0000_3106);

    applyStimulus(0, 0, 0, 1, 32'h0000_4000);
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("top+1 FetchErr_D", {31'd0, FetchErr_D}, 32'd1);
    checkOutput("top+1 Instr_D", Instr_D, 32'd0);

    applyStimulus(0, 0, 0, 1, 32'h0000_3FFC);
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("last word FetchErr_D", {31'd0, FetchErr_D}, 32'd0);
    checkOutput("last word Instr_D", Instr_D, 32'hA000_03FF);

    applyStimulus(0, 0, 0, 1, 32'h0000_2FFC);
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("below base FetchErr_D", {31'd0, FetchErr_D}, 32'd1);

    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("wrap PC_F", PC_F, 32'd0);
    checkOutput("wrap PC8_D", PC8_D, 32'h0000_0004);
    checkOutput("wrap FetchErr_D", {31'd0, FetchErr_D}, 32'd1);

    applyStimulus(0, 0, 0, 1, 32'h0000_3000);
    applyStimulus(1, 0, 0, 0, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async reset");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'd0);
    checkOutput("after reset Instr_D", Instr_D, 32'h1111_1111);
    checkOutput("after reset PC_D", PC_D, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
